rps_match_scorer: RTL and testbench

Match-level score keeper for the stone-paper-scissors game, directly downstream of the round evaluator. Samples each round's 2-bit winner code on a valid strobe, tallies per-player scores, round and invalid counts, and declares the match winner when a player reaches the target score. All outputs are registered and drive the display and debug logic.

---
 rtl/rps_pkg.sv | 18 +
 rtl/rps_match_scorer_if.sv | 32 +++
 rtl/rps_sat_counter.sv | 27 ++
 rtl/rps_match_scorer.sv | 149 ++++++++++++++
 tb/tb_rps_match_scorer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/rps_pkg.sv
// Shared definitions for the stone-paper-scissors blocks.
// Winner codes as produced by the round evaluator, and the match scorer state encoding.
// Pure definitions; no logic.
package rps_pkg;

  localparam logic [1:0] WIN_TIE     = 2'b00;
  localparam logic [1:0] WIN_P1      = 2'b01;
  localparam logic [1:0] WIN_P2      = 2'b10;
  localparam logic [1:0] WIN_INVALID = 2'b11;

  // 2'b11 is deliberately left unencoded; the scorer steers it back to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/rps_match_scorer_if.sv
// Bundle between the round evaluator (master) and the match scorer (slave).
// The master drives the round strobe and code; the slave returns the registered tallies.
// No backpressure: the slave accepts a result on every cycle.
interface rps_match_scorer_if #(
  parameter int SCORE_W = 4
);

  logic               new_match;
  logic               result_valid;
  logic [1:0]         winner;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [7:0]         round_count;
  logic [3:0]         invalid_count;
  logic               match_over;
  logic [1:0]         match_winner;
  logic               score_event;
  logic [1:0]         state;

  modport master (
    output new_match, result_valid, winner,
    input  p1_score, p2_score, round_count, invalid_count,
           match_over, match_winner, score_event, state
  );

  modport slave (
    input  new_match, result_valid, winner,
    output p1_score, p2_score, round_count, invalid_count,
           match_over, match_winner, score_event, state
  );

endinterface

// File: rtl/rps_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects clr/inc one cycle after the edge that samples them.
// No backpressure; once all ones, further increments are dropped.
module rps_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Clear has priority over increment; the counter holds at its maximum value.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (inc && !(&count_q)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rps_match_scorer.sv
// Match scorer: tallies round results and declares a first-to-WIN_TARGET winner.
// Latency: every output updates one cycle after the edge sampling result_valid/new_match.
// No backpressure. Optional tie-streak draw rule: define RPS_TIE_LIMIT_EN.
module rps_match_scorer
  import rps_pkg::*;
#(
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 4,
  parameter int TIE_LIMIT  = 5
) (
  input  logic               clk,
  input  logic               reset,
  rps_match_scorer_if.slave  bus
);

  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

  state_t             state_q;
  logic [SCORE_W-1:0] p1_q, p2_q;
  logic [SCORE_W-1:0] p1_d, p2_d;
  logic               match_over_q;
  logic [1:0]         match_winner_q;
  logic               score_event_q;
  logic [7:0]         round_cnt;
  logic [3:0]         invalid_cnt;
  logic               accept;

  // A result only counts in S_PLAY and loses to a simultaneous new_match.
  assign accept = bus.result_valid && !bus.new_match && (state_q == S_PLAY);
  assign p1_d   = p1_q + SCORE_W'(1);
  assign p2_d   = p2_q + SCORE_W'(1);

`ifdef RPS_TIE_LIMIT_EN
  localparam int TIE_W = $clog2(TIE_LIMIT + 1);
  logic [TIE_W-1:0] tie_q, tie_d;
  assign tie_d = tie_q + TIE_W'(1);
`else
  logic unused_tie_cfg;
  assign unused_tie_cfg = |TIE_LIMIT;
`endif

  rps_sat_counter #(.W(8)) u_round_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.new_match),
    .inc   (accept && (bus.winner != WIN_INVALID)),
    .count (round_cnt)
  );

  rps_sat_counter #(.W(4)) u_invalid_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.new_match),
    .inc   (accept && (bus.winner == WIN_INVALID)),
    .count (invalid_cnt)
  );

  // Match FSM with scores and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      p1_q           <= '0;
      p2_q           <= '0;
      match_over_q   <= 1'b0;
      match_winner_q <= WIN_TIE;
      score_event_q  <= 1'b0;
`ifdef RPS_TIE_LIMIT_EN
      tie_q          <= '0;
`endif
    end else if (bus.new_match) begin
      state_q        <= S_PLAY;
      p1_q           <= '0;
      p2_q           <= '0;
      match_over_q   <= 1'b0;
      match_winner_q <= WIN_TIE;
      score_event_q  <= 1'b0;
`ifdef RPS_TIE_LIMIT_EN
      tie_q          <= '0;
`endif
    end else begin
      score_event_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          // Results are ignored and tallies are frozen until new_match.
        end
        S_PLAY: begin
          if (bus.result_valid) begin
            case (bus.winner)
              WIN_P1: begin
                p1_q          <= p1_d;
                score_event_q <= 1'b1;
`ifdef RPS_TIE_LIMIT_EN
                tie_q         <= '0;
`endif
                if (p1_d == TARGET) begin
                  state_q        <= S_DONE;
                  match_over_q   <= 1'b1;
                  match_winner_q <= WIN_P1;
                end
              end
              WIN_P2: begin
                p2_q          <= p2_d;
                score_event_q <= 1'b1;
`ifdef RPS_TIE_LIMIT_EN
                tie_q         <= '0;
`endif
                if (p2_d == TARGET) begin
                  state_q        <= S_DONE;
                  match_over_q   <= 1'b1;
                  match_winner_q <= WIN_P2;
                end
              end
              WIN_TIE: begin
                // A tie only moves the visible tallies while round_count can still count.
                score_event_q <= (round_cnt != 8'hFF);
`ifdef RPS_TIE_LIMIT_EN
                tie_q         <= tie_d;
                if (tie_d == TIE_W'(TIE_LIMIT)) begin
                  state_q        <= S_DONE;
                  match_over_q   <= 1'b1;
                  match_winner_q <= WIN_TIE;
                end
`endif
              end
              default: begin
                score_event_q <= (invalid_cnt != 4'hF);
              end
            endcase
          end
        end
        default: begin
          state_q        <= S_IDLE;
          match_over_q   <= 1'b0;
          match_winner_q <= WIN_TIE;
        end
      endcase
    end
  end

  assign bus.p1_score      = p1_q;
  assign bus.p2_score      = p2_q;
  assign bus.round_count   = round_cnt;
  assign bus.invalid_count = invalid_cnt;
  assign bus.match_over    = match_over_q;
  assign bus.match_winner  = match_winner_q;
  assign bus.score_event   = score_event_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_rps_match_scorer.sv
// Bench for rps_match_scorer: directed scenarios then random rounds against a reference model.
// Every cycle the full output set is compared one step after the active edge.
// Inputs are driven just after each edge so they are stable for the next one.
module tb_rps_match_scorer;

  localparam int WIN_TARGET = 3;
  localparam int SCORE_W    = 4;
  localparam int TIE_LIMIT  = 5;
`ifdef RPS_TIE_LIMIT_EN
  localparam bit TIE_EN = 1'b1;
`else
  localparam bit TIE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  // Reference model: match status as plain integers.
  int m_p1, m_p2, m_rounds, m_inv, m_ties, m_over, m_mw, m_state, m_evt;

  rps_match_scorer_if #(.SCORE_W(SCORE_W)) bus();

  rps_match_scorer #(
    .WIN_TARGET (WIN_TARGET),
    .SCORE_W    (SCORE_W),
    .TIE_LIMIT  (TIE_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_p1 = 0; m_p2 = 0; m_rounds = 0; m_inv = 0; m_ties = 0;
    m_over = 0; m_mw = 0; m_evt = 0;
  endtask

  task automatic model_finish(input int who);
    m_over  = 1;
    m_mw    = who;
    m_state = 2;
  endtask

  // One clock edge of match rules; states 0 idle, 1 play, 2 done.
  task automatic model(input bit rst, input bit nm, input bit rv, input bit [1:0] w);
    m_evt = 0;
    if (rst) begin
      model_clear();
      m_state = 0;
    end else if (nm) begin
      model_clear();
      m_state = 1;
    end else if (m_state == 1 && rv) begin
      if (w == 2'd3) begin
        if (m_inv < 15) begin
          m_inv++;
          m_evt = 1;
        end
      end else begin
        if (m_rounds < 255) begin
          m_rounds++;
          m_evt = 1;
        end
        if (w == 2'd1) begin
          m_p1++;
          m_evt = 1;
          m_ties = 0;
          if (m_p1 == WIN_TARGET) model_finish(1);
        end else if (w == 2'd2) begin
          m_p2++;
          m_evt = 1;
          m_ties = 0;
          if (m_p2 == WIN_TARGET) model_finish(2);
        end else begin
          m_ties++;
          if (TIE_EN && m_ties == TIE_LIMIT) model_finish(0);
        end
      end
    end
  endtask

  task automatic check_all();
    chk("p1_score",      32'(bus.p1_score),      32'(m_p1));
    chk("p2_score",      32'(bus.p2_score),      32'(m_p2));
    chk("round_count",   32'(bus.round_count),   32'(m_rounds));
    chk("invalid_count", 32'(bus.invalid_count), 32'(m_inv));
    chk("match_over",    32'(bus.match_over),    32'(m_over));
    chk("match_winner",  32'(bus.match_winner),  32'(m_mw));
    chk("score_event",   32'(bus.score_event),   32'(m_evt));
    chk("state",         32'(bus.state),         32'(m_state));
  endtask

  task automatic step(input bit rst, input bit nm, input bit rv, input bit [1:0] w);
    reset            = rst;
    bus.new_match    = nm;
    bus.result_valid = rv;
    bus.winner       = rv ? w : 2'($urandom_range(3, 0));
    @(posedge clk);
    model(rst, nm, rv, w);
    #1;
    reset            = 1'b0;
    bus.new_match    = 1'b0;
    bus.result_valid = 1'b0;
    check_all();
  endtask

  initial begin
    bus.new_match    = 1'b0;
    bus.result_valid = 1'b0;
    bus.winner       = 2'b00;
    model_clear();
    m_state = 0;

    // Reset state, and a result in S_IDLE is ignored.
    step(1, 0, 0, 2'd0);
    step(1, 0, 0, 2'd0);
    step(0, 0, 1, 2'd1);
    chk("idle_ignores_p1", 32'(bus.p1_score), 32'd0);

    // P1 wins three straight; a later P2 result is ignored in S_DONE.
    step(0, 1, 0, 2'd0);
    step(0, 0, 1, 2'd1);
    step(0, 0, 1, 2'd1);
    step(0, 0, 1, 2'd1);
    chk("tp1_p1_score", 32'(bus.p1_score), 32'd3);
    chk("tp1_over",     32'(bus.match_over), 32'd1);
    chk("tp1_winner",   32'(bus.match_winner), 32'd1);
    step(0, 0, 1, 2'd2);
    chk("tp1_p2_frozen", 32'(bus.p2_score), 32'd0);

    // Mixed sequence with one invalid round, P2 takes it.
    step(0, 1, 0, 2'd0);
    step(0, 0, 1, 2'd2);
    step(0, 0, 1, 2'd1);
    step(0, 0, 1, 2'd3);
    step(0, 0, 1, 2'd2);
    step(0, 0, 1, 2'd2);
    chk("tp2_p2_score", 32'(bus.p2_score), 32'd3);
    chk("tp2_p1_score", 32'(bus.p1_score), 32'd1);
    chk("tp2_invalid",  32'(bus.invalid_count), 32'd1);
    chk("tp2_rounds",   32'(bus.round_count), 32'd4);
    chk("tp2_winner",   32'(bus.match_winner), 32'd2);

    // new_match beats a simultaneous result.
    step(0, 1, 1, 2'd1);
    chk("tp3_p1_score", 32'(bus.p1_score), 32'd0);
    chk("tp3_state",    32'(bus.state), 32'd1);

    // Reset in the middle of a match, then a result in S_IDLE.
    step(0, 0, 1, 2'd1);
    step(0, 0, 1, 2'd1);
    chk("tp4_p1_before", 32'(bus.p1_score), 32'd2);
    step(1, 0, 0, 2'd0);
    chk("tp4_state", 32'(bus.state), 32'd0);
    step(0, 0, 1, 2'd2);

    // Invalid count saturates; scores and rounds untouched.
    step(0, 1, 0, 2'd0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 2'd3);
    chk("tp5_invalid_sat", 32'(bus.invalid_count), 32'd15);
    chk("tp5_rounds",      32'(bus.round_count), 32'd0);

    // Tie streak: four ties, a P1 win, then five ties.
    step(0, 1, 0, 2'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 2'd0);
    step(0, 0, 1, 2'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 2'd0);
    chk("tp6_rounds", 32'(bus.round_count), 32'd10);
    chk("tp6_over",   32'(bus.match_over), 32'(TIE_EN));
    chk("tp6_winner", 32'(bus.match_winner), 32'd0);

    // Random traffic, including back-to-back results and occasional restarts.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63, 0) == 0),
           ($urandom_range(11, 0) == 0),
           ($urandom_range(3, 0) != 0),
           2'($urandom_range(3, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
